seq_bypass_mul: RTL
===================

# seq_bypass_mul

Parametrised, sequential, unsigned W×W multiplier with row bypassing. It retires one multiplier row per clock and skips the add for zero rows. It terminates as soon as the remaining multiplier bits are all zero, so latency tracks the most-significant set bit of `b`. Operands enter and the product leaves through valid/ready handshakes, so the block can sit between pipeline stages of the arithmetic datapath in place of the fixed combinational array multipliers.

## Interface
- `W`, default 4: operand width in bits; legal range W ≥ 2.
- `CW`, default $clog2(W+1): width of the row-count output.

- `clk`  input  1  the single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operand pair on `a`/`b` is valid.
- `in_ready`  output  1  block accepts operands; high only in IDLE.
- `a`  input  W  multiplicand, unsigned.
- `b`  input  W  multiplier, unsigned.
- `out_valid`  output  1  `y` and `rows` hold a finished result.
- `out_ready`  input  1  consumer takes the result.
- `y`  output  2W  product a·b.
- `rows`  output  CW  number of partial-product rows actually added.

## Operation
- Internal registers:
  - `mcand` (2W bits), `mplier` (W bits), `acc` (2W bits), `cnt` (CW bits).
  - State: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, load `mcand`={W'b0,a}, `mplier`=b, `acc`=0, `cnt`=0.
  - If a==0 or b==0, go to DONE (bypass all rows). Otherwise go to RUN.
- RUN, each cycle:
  - If `mplier[0]`: `acc`←`acc`+`mcand` and `cnt`←`cnt`+1. Otherwise `acc` and `cnt` hold; this is the bypassed row and no add is performed.
  - `mcand`←`mcand`<<1; `mplier`←`mplier`>>1.
  - If `mplier[W-1:1]`==0, go to DONE.
- DONE:
  - `out_valid`=1, `y`=`acc`, `rows`=`cnt`.
  - On `out_ready`, go to IDLE.
- Arithmetic:
  - Unsigned; 2W-bit accumulation.
  - The product never exceeds (2^W−1)², so no carry is lost.
  - The carry out of the 2W-bit add is discarded by construction.
- `in_valid` is ignored outside IDLE. Operands are captured only at acceptance; later changes on `a`/`b` have no effect.
- `y` and `rows` hold their values throughout DONE, including under backpressure. Outside DONE both read 0.
- `rows` equals popcount(b) when a≠0, and 0 when a==0 or b==0.

## Timing
- Reset values:
  - State=IDLE; `in_ready`=1; `out_valid`=0; `y`=0; `rows`=0.
  - Internal registers are 0.
- Reset asserted mid-RUN or mid-DONE:
  - Immediately (asynchronously) abandons the operation. The pending result is lost and never presented.
  - The block is in IDLE after deassertion.
- Latency: let k = (index of the most-significant set bit of b)+1.
  - `out_valid` rises k clock edges after the acceptance edge.
  - For a==0 or b==0 it rises on the acceptance edge itself, i.e. in the cycle immediately after acceptance.
  - Maximum latency is W edges, when b[W-1]=1.
- Throughput:
  - One operation in flight.
  - The earliest next acceptance is the cycle after the `out_valid`&`out_ready` handshake, i.e. one IDLE cycle between results.
- Handshakes:
  - A transfer occurs only on a rising edge with valid&ready both high.
  - `in_ready` and `out_valid` are pure decodes of the state register; there is no combinational path from inputs to outputs.

## Test plan
- W=4, reset then a=15, b=15:
  - Result: `y`=225, `rows`=4.
  - `out_valid` rises exactly 4 edges after acceptance.
  - `in_ready`=0 from acceptance until the cycle after the output handshake.
- W=4, a=15, b=8:
  - Result: `y`=120, `rows`=1, latency 4 (three bypassed rows).
  - Then a=9, b=1: `y`=9, `rows`=1, latency 1.
- W=4, a=13, b=0 and then a=0, b=11:
  - Result: `y`=0, `rows`=0 each time.
  - `out_valid` is high in the cycle following acceptance.
- Backpressure, W=4, a=6, b=5:
  - Hold `out_ready`=0 for 5 cycles after `out_valid` rises, and drive `in_valid`=1 with new operands throughout.
  - Required: `y`=30 and `rows`=2 stable for all 5 cycles; new operands not accepted; `in_ready`=0.
- Reset mid-RUN, W=4, a=15, b=15:
  - Assert `rst` one edge after acceptance; deassert two cycles later.
  - Required: `out_valid`, `y` and `rows` read 0 immediately on `rst` assertion; the block is in IDLE with `in_ready`=1 once `rst` is deasserted.
  - Then a=3, b=3 gives `y`=9, `rows`=2, latency 2.
- Exhaustive, W=4 and W=8 (random 10,000 pairs for W=8):
  - Random `in_valid` and `out_ready` gaps.
  - Required for every result: `y`==a·b, `rows`==popcount(b) (0 if a==0), latency==k.

Source files
------------

// File: rtl/seq_bypass_mul.sv
// Sequential unsigned W x W shift-add multiplier that skips zero multiplier rows
// and stops as soon as no set multiplier bits remain.
module seq_bypass_mul #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  y,
    output logic [CW-1:0]   rows
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready/out_valid decode the state register only.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{W{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    // A zero operand means every row is bypassed.
                    state_d  = ((a == '0) || (b == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                    cnt_d = cnt_q + CW'(1);
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                // Terminate once the bits still to be shifted in are all zero.
                if (mplier_q[W-1:1] == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = out_valid ? acc_q : '0;
    assign rows      = out_valid ? cnt_q : '0;

endmodule
